// File: rtl/pwr_cntr_reader.sv
// pwr_cntr_reader
// Sequential readout engine for the power-counter memory. A START request in
// IDLE walks addresses 0..NUM_CNTR, reads each 32-bit count over dir/LE/dato,
// presents it on a valid/ready port and accumulates a 40-bit grand total.
//
// Build option: define PWR_CLEAR_ON_READ_EN to write each counter back to
// zero right after it is captured (two extra states per counter). Without it
// the scan is read-only, LE is tied high and dato is never driven.
`timescale 1ns/1ps

module pwr_cntr_reader #(
    parameter int unsigned NDIR     = 7,
    parameter int unsigned NUM_CNTR = 15
) (
    input  logic          CLK,
    input  logic          RESET_L,
    input  logic          START,
    output logic [NDIR:0] dir,
    output logic          LE,
    inout  wire  [31:0]   dato,
    output logic [31:0]   OUT_DATA,
    output logic [NDIR:0] OUT_IDX,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [39:0]   TOTAL,
    output logic          BUSY,
    output logic          DONE
);

    localparam int unsigned    IDX_W    = NDIR + 1;
    localparam logic [NDIR:0]  LAST_IDX = IDX_W'(NUM_CNTR);
    localparam logic [NDIR:0]  IDX_ONE  = {{NDIR{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_CAPT    = 3'd2,
`ifdef PWR_CLEAR_ON_READ_EN
        ST_CLR0    = 3'd3,
        ST_CLR1    = 3'd4,
`endif
        ST_PRESENT = 3'd5,
        ST_FIN     = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [NDIR:0] idx_q, idx_d;
    logic          capture;
    logic          clear_total;

    // The memory address always equals the scan index. The index only moves
    // on IDLE->SETUP and PRESENT->SETUP, both with LE high, so the memory
    // never sees an address change while it is in write mode.
    assign dir = idx_q;

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        idx_d       = idx_q;
        capture     = 1'b0;
        clear_total = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    clear_total = 1'b1;
                    idx_d       = '0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                capture = 1'b1;
`ifdef PWR_CLEAR_ON_READ_EN
                state_d = ST_CLR0;
`else
                state_d = ST_PRESENT;
`endif
            end
`ifdef PWR_CLEAR_ON_READ_EN
            ST_CLR0: begin
                state_d = ST_CLR1;
            end
            ST_CLR1: begin
                state_d = ST_PRESENT;
            end
`endif
            ST_PRESENT: begin
                if (OUT_READY) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and scan-index registers.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of every other register.
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Registered outputs, decoded from the state being entered so each one
    // changes on the same edge as the state itself.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            OUT_DATA  <= '0;
            OUT_IDX   <= '0;
            OUT_VALID <= 1'b0;
            TOTAL     <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            OUT_VALID <= (state_d == ST_PRESENT);
            BUSY      <= (state_d != ST_IDLE);
            DONE      <= (state_d == ST_FIN);
            if (capture) begin
                OUT_DATA <= dato;
                OUT_IDX  <= idx_q;
            end
            // Total is cleared only by an accepted START, so it survives FIN.
            if (clear_total) begin
                TOTAL <= '0;
            end else if (capture) begin
                TOTAL <= TOTAL + {8'h00, dato};
            end
        end
    end

`ifdef PWR_CLEAR_ON_READ_EN
    logic le_q;
    logic drive_q;

    // Memory write strobe and data-bus driver for the clear-after-read cycle.
    // Reset releases the bus and returns LE high asynchronously.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            le_q    <= 1'b1;
            drive_q <= 1'b0;
        end else begin
            le_q    <= (state_d != ST_CLR0);
            drive_q <= (state_d == ST_CLR0) || (state_d == ST_CLR1);
        end
    end

    assign LE   = le_q;
    assign dato = drive_q ? 32'h0000_0000 : 32'bz;
`else
    // Read-only scan: the memory stays in read mode and dato is only sampled.
    assign LE = 1'b1;
`endif

endmodule

// File: tb/tb_pwr_cntr_reader.sv
// Directed testbench for pwr_cntr_reader: a behavioural model of the counter
// memory sits on dir/LE/dato, and each directed step checks the outputs with
// immediate assertions. Expectations follow PWR_CLEAR_ON_READ_EN when defined.
`timescale 1ns/1ps

module tb_pwr_cntr_reader;

    localparam int NDIR   = 7;
    localparam int NWORDS = 16;
`ifdef PWR_CLEAR_ON_READ_EN
    localparam int SCAN_CYCLES = 81;
`else
    localparam int SCAN_CYCLES = 49;
`endif

    logic            CLK = 1'b0;
    logic            RESET_L;
    logic            START;
    logic [NDIR:0]   dir;
    logic            LE;
    wire  [31:0]     dato;
    logic [31:0]     OUT_DATA;
    logic [NDIR:0]   OUT_IDX;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [39:0]     TOTAL;
    logic            BUSY;
    logic            DONE;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem      [0:255];
    logic [31:0] exp_data [0:NWORDS-1];
    logic        mem_en;
    logic [NDIR:0] prev_dir;

    pwr_cntr_reader #(.NDIR(NDIR), .NUM_CNTR(15)) dut (
        .CLK       (CLK),
        .RESET_L   (RESET_L),
        .START     (START),
        .dir       (dir),
        .LE        (LE),
        .dato      (dato),
        .OUT_DATA  (OUT_DATA),
        .OUT_IDX   (OUT_IDX),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .TOTAL     (TOTAL),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    // Memory model: combinational read while LE is high, write on a clock
    // edge while LE is low.
    assign dato = (mem_en && LE === 1'b1) ? mem[dir] : 32'bz;

    always @(posedge CLK) begin
        if (LE === 1'b0) mem[dir] = dato;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus safety monitor.
    always @(negedge CLK) begin
        if (RESET_L === 1'b1) begin
`ifdef PWR_CLEAR_ON_READ_EN
            if (LE === 1'b0) check("dir_stable_while_le0", dir, prev_dir);
`else
            check("le_always_high", LE, 1'b1);
            if (mem_en) check("dato_not_driven_by_dut", dato, mem[dir]);
`endif
        end
        prev_dir = dir;
    end

    task automatic load_mem(input bit all_ones);
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < NWORDS; i++) begin
            mem[i]      = all_ones ? 32'hFFFF_FFFF : 32'(i + 1);
            exp_data[i] = mem[i];
        end
    endtask

    // One full scan from IDLE: optional 5-cycle stall on word stall_idx and
    // optional extra START pulse once restart_idx words have been taken.
    task automatic run_scan(input string name, input int stall_idx, input int restart_idx,
                            input logic [39:0] exp_total, input int exp_cycles);
        int          words, dones, busy_cyc, stall_cnt;
        bit          restarted, finished;
        logic [31:0] held;
        words = 0; dones = 0; busy_cyc = 0; stall_cnt = 0;
        restarted = 1'b0; finished = 1'b0; held = '0;
        OUT_READY = 1'b1;
        START     = 1'b1;
        @(negedge CLK);
        START     = 1'b0;
        for (int c = 0; c < 1000 && !finished; c++) begin
            if (BUSY === 1'b1) busy_cyc++;
            if (DONE === 1'b1) dones++;
            START = 1'b0;
            if (restart_idx >= 0 && !restarted && words == restart_idx) begin
                START     = 1'b1;
                restarted = 1'b1;
            end
            if (OUT_VALID === 1'b1) begin
                if (int'(OUT_IDX) == stall_idx && stall_cnt < 5) begin
                    if (stall_cnt == 0) held = OUT_DATA;
                    else check({name, "_stall_data_hold"}, OUT_DATA, held);
                    stall_cnt++;
                    OUT_READY = 1'b0;
                end else begin
                    OUT_READY = 1'b1;
                    check({name, "_idx"}, OUT_IDX, words);
                    if (words < NWORDS) check({name, "_data"}, OUT_DATA, exp_data[words]);
                    words++;
                end
            end
            if (BUSY !== 1'b1) finished = 1'b1;
            else @(negedge CLK);
        end
        START     = 1'b0;
        OUT_READY = 1'b1;
        check({name, "_finished"}, finished, 1'b1);
        check({name, "_words"}, words, NWORDS);
        check({name, "_done_pulses"}, dones, 1);
        check({name, "_busy_cycles"}, busy_cyc, exp_cycles);
        check({name, "_total"}, TOTAL, exp_total);
        check({name, "_done_low_after"}, DONE, 1'b0);
        if (stall_idx >= 0) check({name, "_stall_cycles"}, stall_cnt, 5);
    endtask

    initial begin
        bit found;
        RESET_L   = 1'b0;
        START     = 1'b0;
        OUT_READY = 1'b1;
        mem_en    = 1'b0;
        load_mem(1'b0);
        repeat (2) @(negedge CLK);

        // Reset values.
        check("rst_dir", dir, 0);
        check("rst_le", LE, 1'b1);
        check("rst_dato_z", (dato === 32'bz), 1'b1);
        check("rst_out_data", OUT_DATA, 0);
        check("rst_out_idx", OUT_IDX, 0);
        check("rst_out_valid", OUT_VALID, 1'b0);
        check("rst_total", TOTAL, 0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_done", DONE, 1'b0);

        mem_en  = 1'b1;
        RESET_L = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("idle_no_start_busy", BUSY, 1'b0);

        // Basic scan: values 1..16, total 136.
        load_mem(1'b0);
        run_scan("basic", -1, -1, 40'd136, SCAN_CYCLES);
        repeat (3) @(negedge CLK);
        check("total_holds_after_fin", TOTAL, 40'd136);
        check("idle_after_scan", BUSY, 1'b0);

        // Backpressure on word 3.
        load_mem(1'b0);
        run_scan("backpressure", 3, -1, 40'd136, SCAN_CYCLES + 5);

        // START while busy at word 5 is ignored.
        load_mem(1'b0);
        run_scan("start_busy", -1, 5, 40'd136, SCAN_CYCLES);

        // All-ones scan, then a second scan (cleared or repeated).
        load_mem(1'b1);
        run_scan("ones_first", -1, -1, 40'hF_FFFF_FFF0, SCAN_CYCLES);
`ifdef PWR_CLEAR_ON_READ_EN
        for (int i = 0; i < NWORDS; i++) exp_data[i] = 32'h0;
        run_scan("ones_second", -1, -1, 40'h0, SCAN_CYCLES);
`else
        run_scan("ones_second", -1, -1, 40'hF_FFFF_FFF0, SCAN_CYCLES);
`endif

        // Reset mid-scan while word 7 is presented.
        load_mem(1'b0);
        OUT_READY = 1'b1;
        START     = 1'b1;
        @(negedge CLK);
        START     = 1'b0;
        found     = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (OUT_VALID === 1'b1 && OUT_IDX === 8'd7) begin
                found     = 1'b1;
                OUT_READY = 1'b0;
            end else begin
                @(negedge CLK);
            end
        end
        check("midscan_reached_word7", found, 1'b1);
        mem_en  = 1'b0;
        RESET_L = 1'b0;
        #1;
        check("midscan_rst_le", LE, 1'b1);
        check("midscan_rst_dato_z", (dato === 32'bz), 1'b1);
        check("midscan_rst_valid", OUT_VALID, 1'b0);
        check("midscan_rst_busy", BUSY, 1'b0);
        check("midscan_rst_done", DONE, 1'b0);
        check("midscan_rst_total", TOTAL, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check("midscan_no_done", DONE, 1'b0);
        end
        mem_en    = 1'b1;
        OUT_READY = 1'b1;
        RESET_L   = 1'b1;
        @(negedge CLK);
        check("midscan_idle_after_release", BUSY, 1'b0);
        load_mem(1'b0);
        run_scan("rescan", -1, -1, 40'd136, SCAN_CYCLES);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
